arb_mux: RTL and testbench
==========================

ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter WIDTH, default 2, bit width of each data channel.
REQ-002 Parameter NUM_IN, default 4, number of input channels (2..16).
REQ-003 Parameter SEL_W, default 2, width of select/source fields, SHALL equal ceil(log2(NUM_IN)).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  NUM_IN*WIDTH  packed channel data; channel i at bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  NUM_IN  per-channel valid.
REQ-008 in_ready  output  NUM_IN  per-channel ready; at most one bit high per cycle.
REQ-009 mode  input  1  0 = direct select by sel, 1 = round-robin arbitration.
REQ-010 sel  input  SEL_W  channel index used in mode 0; ignored in mode 1.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_valid  output  1  out_data/out_src hold a valid word.
REQ-013 out_ready  input  1  downstream accepts word when out_valid and out_ready both high.
REQ-014 out_src  output  SEL_W  index of the channel that supplied out_data.

Function
REQ-015 Output stage SHALL be one register entry; load_en = !out_valid | out_ready.
REQ-016 Input transfer on channel i SHALL occur when in_valid[i] & in_ready[i]; in_ready[i] = load_en & grant[i], purely combinational from current inputs and state.
REQ-017 Mode 0: grant[sel] SHALL be high only if in_valid[sel]; sel >= NUM_IN SHALL grant nothing.
REQ-018 Mode 1: grant SHALL go to the first valid channel searching upward from (last_ptr+1) mod NUM_IN, wrapping past NUM_IN-1 to 0.
REQ-019 last_ptr SHALL update to the granted index only on an accepted input transfer, in either mode.
REQ-020 No valid channel (or sel invalid in mode 0): all in_ready low, output register loads nothing.
REQ-021 On transfer, out_data <= granted channel data, out_src <= granted index, out_valid <= 1, next cycle (latency 1).
REQ-022 Downstream accept with no new transfer SHALL clear out_valid; out_data/out_src hold last value.
REQ-023 Simultaneous accept and transfer SHALL replace the word in the same edge; sustained throughput 1 word/cycle.
REQ-024 out_valid high with out_ready low: out_data, out_src SHALL remain stable and all in_ready low.
REQ-025 mode or sel change SHALL affect grant in the same cycle; no word in flight is altered.
REQ-026 Input channels not granted SHALL see in_ready low regardless of in_valid.

Reset
REQ-027 reset_n low SHALL immediately force out_valid=0, out_data=0, out_src=0, last_ptr=NUM_IN-1 (first round-robin priority to channel 0).
REQ-028 Reset assertion mid-transfer SHALL discard the buffered word; in_ready SHALL be driven low during reset.
REQ-029 After reset_n deasserts, first transfer SHALL be possible on the first rising edge.

Structure
REQ-030 Shared package SHALL hold the mode encodings (MODE_DIRECT=0, MODE_RR=1) and a constant-function clog2 used to derive SEL_W.
REQ-031 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs: request vector, last_ptr; output: one-hot grant, index, any_grant).
REQ-032 arb_mux SHALL instantiate rr_arbiter once and contain the mode-0 path, last_ptr, and output register.

Verification
REQ-033 Mode 0, sel=2, in_valid=4'b0100, ch2=2'b11, out_ready=1 -> in_ready=4'b0100, next cycle out_data=2'b11, out_src=2, out_valid=1.
REQ-034 Mode 1, in_valid=4'b1111 constant, out_ready=1, after reset -> out_src sequence 0,1,2,3,0 on consecutive cycles.
REQ-035 Mode 1, in_valid=4'b1001, last_ptr=3 -> grant ch0; next grant ch3; then ch0 (wrap-around).
REQ-036 out_valid=1, out_ready=0 for 3 cycles, all inputs valid -> in_ready=0, out_data/out_src unchanged; release out_ready -> new word next edge.
REQ-037 Mode 0, sel=1, in_valid=4'b1101 -> in_ready=0, out_valid falls to 0 after pending word accepted.
REQ-038 reset_n pulled low mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_src=0 without a clock edge; next RR grant goes to ch0.

Source files
------------

// File: rtl/arb_mux_pkg.sv
// arb_mux_pkg -- shared definitions for the arb_mux codebase slice.
//
// Contents:
//   mode_e  : operating mode encoding (direct select / round-robin)
//   clog2() : constant function, ceiling log2, used to size select fields
package arb_mux_pkg;

  // Operating mode of the multiplexer.
  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0, clog2(4) = 2,
  // clog2(5) = 3.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < value) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// rr_arbiter -- combinational round-robin grant selection.
//
// The search starts one past last_ptr and walks upward, wrapping from
// NUM_IN-1 back to 0; the first requesting channel found wins.
//
// Ports:
//   req       : request vector, one bit per channel
//   last_ptr  : index of the most recently served channel
//   grant     : one-hot grant vector (all zero when nothing is requested)
//   grant_idx : binary index of the granted channel (0 when none)
//   any_grant : high when some channel is granted
module rr_arbiter #(
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  last_ptr,
  output logic [NUM_IN-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              any_grant
);

  // Rotating priority search; once a winner is found later candidates are
  // masked by any_grant, so the grant stays one-hot.
  always_comb begin
    logic [SEL_W-1:0] cand_idx_s;
    logic             hit_s;
    grant      = '0;
    grant_idx  = '0;
    any_grant  = 1'b0;
    cand_idx_s = '0;
    hit_s      = 1'b0;
    for (int k = 1; k <= NUM_IN; k++) begin
      cand_idx_s        = SEL_W'((int'(last_ptr) + k) % NUM_IN);
      hit_s             = !any_grant && req[cand_idx_s];
      grant[cand_idx_s] = grant[cand_idx_s] | hit_s;
      grant_idx         = hit_s ? cand_idx_s : grant_idx;
      any_grant         = any_grant | hit_s;
    end
  end

endmodule

// File: rtl/arb_mux.sv
// arb_mux -- N-channel valid/ready multiplexer with a one-entry output
// register. Channel choice is either direct (by sel) or round-robin.
//
// Ports:
//   clk       : clock, rising edge
//   reset_n   : asynchronous active-low reset
//   in_data   : packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid  : per-channel valid
//   in_ready  : per-channel ready, at most one bit high
//   mode      : 0 = direct select by sel, 1 = round-robin
//   sel       : channel index for direct mode (values >= NUM_IN grant nothing)
//   out_data  : registered selected data
//   out_valid : out_data/out_src hold a valid word
//   out_ready : downstream accept
//   out_src   : index of the channel that supplied out_data
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_src
);

  logic [SEL_W-1:0]  last_ptr_r;
  logic              out_valid_r;
  logic [WIDTH-1:0]  out_data_r;
  logic [SEL_W-1:0]  out_src_r;

  logic [NUM_IN-1:0] rr_grant_s;
  logic [SEL_W-1:0]  rr_idx_s;
  logic              rr_any_s;

  logic [NUM_IN-1:0] dir_grant_s;
  logic              dir_any_s;

  logic [NUM_IN-1:0] grant_s;
  logic [SEL_W-1:0]  grant_idx_s;
  logic              grant_any_s;

  logic              load_en_s;
  logic              xfer_s;
  logic [WIDTH-1:0]  sel_data_s;

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_rr_arbiter (
    .req       (in_valid),
    .last_ptr  (last_ptr_r),
    .grant     (rr_grant_s),
    .grant_idx (rr_idx_s),
    .any_grant (rr_any_s)
  );

  // Direct-mode grant: compare sel against each existing channel index, so an
  // out-of-range sel simply matches nothing.
  always_comb begin
    dir_grant_s = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      dir_grant_s[i] = (sel == SEL_W'(i)) && in_valid[i];
    end
    dir_any_s = |dir_grant_s;
  end

  // Pick the grant source for the current mode.
  always_comb begin
    grant_s     = '0;
    grant_idx_s = '0;
    grant_any_s = 1'b0;
    case (mode)
      MODE_DIRECT: begin
        grant_s     = dir_grant_s;
        grant_idx_s = sel;
        grant_any_s = dir_any_s;
      end
      MODE_RR: begin
        grant_s     = rr_grant_s;
        grant_idx_s = rr_idx_s;
        grant_any_s = rr_any_s;
      end
      default: begin
        grant_s     = '0;
        grant_idx_s = '0;
        grant_any_s = 1'b0;
      end
    endcase
  end

  // Handshake: the output register can take a word when empty or draining.
  // in_ready is forced low while reset is asserted.
  always_comb begin
    load_en_s = !out_valid_r || out_ready;
    xfer_s    = load_en_s && grant_any_s && reset_n;
    in_ready  = reset_n ? (grant_s & {NUM_IN{load_en_s}}) : '0;
  end

  // Data mux driven by the granted index.
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      sel_data_s = (grant_idx_s == SEL_W'(i)) ? in_data[i*WIDTH +: WIDTH] : sel_data_s;
    end
  end

  // Output register: load on transfer, clear valid on a bare accept; data and
  // source hold their last value when valid drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_src_r   <= '0;
    end else if (xfer_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= sel_data_s;
      out_src_r   <= grant_idx_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Round-robin pointer follows every accepted transfer in either mode; it
  // resets to NUM_IN-1 so channel 0 has first priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_ptr_r <= SEL_W'(NUM_IN - 1);
    end else if (xfer_s) begin
      last_ptr_r <= grant_idx_s;
    end else begin
      last_ptr_r <= last_ptr_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_src   = out_src_r;

endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux -- self-checking bench for arb_mux (WIDTH=2, NUM_IN=4).
// A behavioural model tracks the output word and the last served channel;
// a negedge process compares every cycle, and directed steps pin literals.
module tb_arb_mux;
  localparam int W = 2;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b1;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic           mode = 1'b0;
  logic [1:0]     sel = 2'd0;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [1:0]     out_src;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state
  bit         m_valid = 1'b0;
  logic [1:0] m_data  = 2'd0;
  int         m_src   = 0;
  int         m_last  = N - 1;

  arb_mux #(.WIDTH(W), .NUM_IN(N), .SEL_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [1:0] chan(input int i);
    return in_data[i*W +: W];
  endfunction

  // Which channel the rules say is granted, or -1. Round-robin: lowest valid
  // index above the last served one, otherwise lowest valid index overall.
  function automatic int pick();
    int first;
    int best;
    first = -1;
    best  = -1;
    if (mode == 1'b0) return in_valid[sel] ? int'(sel) : -1;
    for (int i = 0; i < N; i++) begin
      if (in_valid[i]) begin
        if (first < 0) first = i;
        if (best < 0 && i > m_last) best = i;
      end
    end
    return (best >= 0) ? best : first;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    if (!reset_n) return '0;
    g = pick();
    if ((!m_valid || out_ready) && g >= 0) return N'(1 << g);
    return '0;
  endfunction

  // Model update at each clock edge, reset asynchronously.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 1'b0; m_data <= 2'd0; m_src <= 0; m_last <= N - 1;
    end else if ((!m_valid || out_ready) && pick() >= 0) begin
      m_valid <= 1'b1; m_data <= chan(pick()); m_src <= pick(); m_last <= pick();
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("cmp_in_ready", 32'(in_ready), 32'(exp_ready()));
    check("cmp_out_valid", 32'(out_valid), 32'(m_valid));
    check("cmp_out_data", 32'(out_data), 32'(m_data));
    check("cmp_out_src", 32'(out_src), 32'(m_src));
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic settle(); #1; endtask
  task automatic out_chk(input string nm, input logic v, input logic [1:0] d, input logic [1:0] s);
    check({nm, "_valid"}, 32'(out_valid), 32'(v));
    check({nm, "_data"}, 32'(out_data), 32'(d));
    check({nm, "_src"}, 32'(out_src), 32'(s));
  endtask

  initial begin
    logic [1:0] rr_seq [5];
    rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    #1 reset_n = 1'b0;
    #1;
    out_chk("reset", 1'b0, 2'd0, 2'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    // Round-robin sweep straight out of reset, one word per cycle.
    mode = 1'b1; in_valid = 4'b1111; in_data = 8'b11_10_01_00; out_ready = 1'b1;
    reset_n = 1'b1;
    settle();
    check("rr_first_ready", 32'(in_ready), 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      out_chk("rr_seq", 1'b1, rr_seq[i], rr_seq[i]);
    end
    // Direct select of channel 2.
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_data = 8'h30;
    settle();
    check("dir2_ready", 32'(in_ready), 32'h4);
    tick();
    out_chk("dir2", 1'b1, 2'b11, 2'd2);
    // Direct select of channel 3 moves the pointer to 3.
    sel = 2'd3; in_valid = 4'b1000; in_data = 8'h80;
    settle();
    check("dir3_ready", 32'(in_ready), 32'h8);
    tick();
    out_chk("dir3", 1'b1, 2'b10, 2'd3);
    // Round-robin wrap between channels 0 and 3.
    mode = 1'b1; in_valid = 4'b1001; in_data = 8'b10_00_00_01;
    settle(); check("wrap_a_ready", 32'(in_ready), 32'h1);
    tick();   out_chk("wrap_a", 1'b1, 2'b01, 2'd0);
    settle(); check("wrap_b_ready", 32'(in_ready), 32'h8);
    tick();   out_chk("wrap_b", 1'b1, 2'b10, 2'd3);
    settle(); check("wrap_c_ready", 32'(in_ready), 32'h1);
    tick();   out_chk("wrap_c", 1'b1, 2'b01, 2'd0);
    // Back-pressure for three cycles with every channel valid.
    in_valid = 4'b1111; in_data = 8'b01_10_11_00; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle(); check("stall_ready", 32'(in_ready), 32'h0);
      tick();   out_chk("stall", 1'b1, 2'b01, 2'd0);
    end
    out_ready = 1'b1;
    settle(); check("release_ready", 32'(in_ready), 32'h2);
    tick();   out_chk("release", 1'b1, 2'b11, 2'd1);
    // Direct select of an idle channel: nothing granted, word drains.
    mode = 1'b0; sel = 2'd1; in_valid = 4'b1101;
    settle(); check("idle_sel_ready", 32'(in_ready), 32'h0);
    tick();   out_chk("drain", 1'b0, 2'b11, 2'd1);
    // Mode change takes effect in the same cycle.
    sel = 2'd0; in_valid = 4'b1111;
    settle(); check("modechg_dir_ready", 32'(in_ready), 32'h1);
    mode = 1'b1;
    settle(); check("modechg_rr_ready", 32'(in_ready), 32'h4);
    tick();   out_chk("modechg", 1'b1, 2'b10, 2'd2);
    // Reset mid-stream: immediate clear, then channel 0 first.
    tick();   out_chk("pre_reset", 1'b1, 2'b01, 2'd3);
    reset_n = 1'b0;
    settle();
    out_chk("async_reset", 1'b0, 2'd0, 2'd0);
    check("async_reset_ready", 32'(in_ready), 32'h0);
    tick();
    out_chk("held_reset", 1'b0, 2'd0, 2'd0);
    reset_n = 1'b1;
    settle(); check("post_reset_ready", 32'(in_ready), 32'h1);
    tick();   out_chk("post_reset", 1'b1, 2'b00, 2'd0);
    // Mixed traffic, checked by the model every cycle.
    for (int i = 0; i < 80; i++) begin
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom_range(0, 15));
      in_data   = 8'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
